// File: rtl/ber_error_injector_if.sv
// Valid/ready word stream between pattern source, injector and link.
// The injector takes the slave side; the source/sink the master side.
interface ber_error_injector_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] out_mask;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_mask
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_mask
  );
endinterface

// File: rtl/ber_error_injector.sv
// LFSR-driven burst bit-error injector on a one-deep valid/ready stage.
// Optional statistics counters: define INJ_STATS_EN.
module ber_error_injector #(
  parameter int          WIDTH = 16,
  parameter int          NBW   = $clog2(WIDTH + 1),
  parameter logic [31:0] SEED  = 32'hACE1_1234
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [15:0]         cfg_rate,
  input  logic [NBW-1:0]      cfg_nbits,
  input  logic [31:0]         cfg_len,
  input  logic                seed_load,
  input  logic [31:0]         seed_val,
  ber_error_injector_if.slave bus,
  output logic                busy,
  output logic                done,
  output logic [31:0]         word_cnt,
  output logic [31:0]         err_cnt
);

  localparam int          SW   = $clog2(WIDTH);
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      lfsr;
  logic [31:0]      lfsr_adv;
  logic [31:0]      remaining;
  logic [31:0]      rem_nxt;
  logic             unbounded;
  logic             unb_nxt;
  logic             done_nxt;
  logic             accept;
  logic             hit;
  logic [SW-1:0]    pos;
  logic [NBW-1:0]   n;
  logic [WIDTH:0]   one_sh;
  logic [WIDTH-1:0] base;
  logic [2*WIDTH-1:0] rot;
  logic [WIDTH-1:0] mask;

  assign bus.in_ready = ~bus.out_valid | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign busy         = (state == RUN);

  assign lfsr_adv = lfsr[0] ? ((lfsr >> 1) ^ TAPS)
                            : (lfsr >> 1);

  // Burst of n ones rotated to start at pos, wrapping around the word.
  always_comb begin
    hit    = (cfg_rate == 16'hFFFF) | (lfsr[15:0] < cfg_rate);
    pos    = SW'(32'(lfsr[31:16]) % WIDTH);
    n      = (32'(cfg_nbits) > WIDTH) ? NBW'(WIDTH) : cfg_nbits;
    one_sh = {{WIDTH{1'b0}}, 1'b1} << n;
    base   = WIDTH'(one_sh - 1'b1);
    rot    = {base, base} << pos;
    mask   = (busy && hit) ? rot[2*WIDTH-1:WIDTH] : '0;
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    unb_nxt   = unbounded;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          rem_nxt   = cfg_len;
          unb_nxt   = (cfg_len == 32'd0);
        end
      end
      RUN: begin
        if (accept && !unbounded)
          rem_nxt = remaining - 32'd1;
        if (abort ||
            (accept && !unbounded && remaining == 32'd1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      unbounded <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= rem_nxt;
      unbounded <= unb_nxt;
      done      <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr <= SEED;
    else if (seed_load)
      lfsr <= (seed_val == 32'd0) ? SEED : seed_val;
    else if (accept && busy)
      lfsr <= lfsr_adv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_mask  <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data ^ mask;
      bus.out_mask  <= mask;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef INJ_STATS_EN
  logic [32:0] wc_sum;
  logic [32:0] ec_sum;

  assign wc_sum = {1'b0, word_cnt} + 33'd1;
  assign ec_sum = {1'b0, err_cnt} + 33'($countones(mask));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
      err_cnt  <= '0;
    end else if (!busy && start) begin
      word_cnt <= '0;
      err_cnt  <= '0;
    end else if (accept && busy) begin
      word_cnt <= wc_sum[32] ? '1 : wc_sum[31:0];
      err_cnt  <= ec_sum[32] ? '1 : ec_sum[31:0];
    end
  end
`else
  assign word_cnt = '0;
  assign err_cnt  = '0;
`endif

endmodule
